// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MIPS MULT/MULTU/DIV/DIVU unit producing HI/LO beside the ALU.
// Optional build macro MULDIV_EARLY_OUT_EN lets a multiply leave CALC once the multiplier drains.
module mult_div_unit #(
    parameter int NB    = 32,
    parameter int NB_OP = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [NB_OP-1:0] i_op,
    input  logic [NB-1:0]    i_data_a,
    input  logic [NB-1:0]    i_data_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [NB-1:0]    o_hi,
    output logic [NB-1:0]    o_lo,
    output logic             o_div_by_zero
);
    localparam int                NB_CNT   = $clog2(NB + 1);
    localparam logic [NB_CNT-1:0] CNT_ZERO = {NB_CNT{1'b0}};
    localparam logic [NB_CNT-1:0] CNT_ONE  = {{(NB_CNT-1){1'b0}}, 1'b1};
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(NB);
    localparam logic [NB-1:0]     ZERO_NB  = {NB{1'b0}};
    localparam logic [NB-1:0]     ONE_NB   = {{(NB-1){1'b0}}, 1'b1};
    localparam logic [2*NB-1:0]   ZERO_2NB = {(2*NB){1'b0}};
    localparam logic [2*NB-1:0]   ONE_2NB  = {{(2*NB-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [NB-1:0] neg_if(input logic [NB-1:0] v, input logic neg);
        logic [NB-1:0] r;
        if (neg) begin
            r = ~v + ONE_NB;
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t             state_r;
    logic [NB_OP-1:0]   op_r;
    logic [NB-1:0]      a_raw_r;
    logic [NB-1:0]      b_raw_r;
    logic [NB_CNT-1:0]  cnt_r;
    logic [2*NB-1:0]    work_r;
    logic [2*NB-1:0]    mcand_r;
    logic [NB-1:0]      mplier_r;
    logic               busy_r;
    logic               done_r;
    logic               dz_r;
    logic [NB-1:0]      hi_r;
    logic [NB-1:0]      lo_r;

    logic               is_div_s;
    logic               sign_a_s;
    logic               sign_b_s;
    logic               b_zero_s;
    logic [NB-1:0]      abs_a_s;
    logic [NB-1:0]      abs_b_s;
    logic [2*NB-1:0]    work_nxt_s;
    logic [2*NB-1:0]    mcand_nxt_s;
    logic [NB-1:0]      mplier_nxt_s;
    logic [NB:0]        trial_s;
    logic               last_iter_s;
    logic [2*NB-1:0]    prod_s;
    logic [NB-1:0]      fix_hi_s;
    logic [NB-1:0]      fix_lo_s;
    logic               fix_dz_s;

    // Operands are held raw; sign handling happens inside the unit, off the shared A/B buses.
    assign is_div_s = op_r[1];
    assign sign_a_s = ~op_r[0] & a_raw_r[NB-1];
    assign sign_b_s = ~op_r[0] & b_raw_r[NB-1];
    assign b_zero_s = (b_raw_r == ZERO_NB);
    assign abs_a_s  = neg_if(a_raw_r, sign_a_s);
    assign abs_b_s  = neg_if(b_raw_r, sign_b_s);

    // One iteration: shift-add multiply step or restoring-divide step on the working registers.
    always_comb begin
        work_nxt_s   = work_r;
        mcand_nxt_s  = mcand_r;
        mplier_nxt_s = mplier_r;
        trial_s      = work_r[2*NB-1:NB-1] - {1'b0, mcand_r[NB-1:0]};
        if (is_div_s) begin
            if (trial_s[NB]) begin
                work_nxt_s = {work_r[2*NB-2:0], 1'b0};
            end else begin
                work_nxt_s = {trial_s[NB-1:0], work_r[NB-2:0], 1'b1};
            end
        end else begin
            if (mplier_r[0]) begin
                work_nxt_s = work_r + mcand_r;
            end else begin
                work_nxt_s = work_r;
            end
            mcand_nxt_s  = {mcand_r[2*NB-2:0], 1'b0};
            mplier_nxt_s = {1'b0, mplier_r[NB-1:1]};
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    assign last_iter_s = (cnt_r == CNT_LAST) || (!is_div_s && (mplier_nxt_s == ZERO_NB));
`else
    assign last_iter_s = (cnt_r == CNT_LAST);
`endif

    // Sign correction of the magnitude results, plus the divide-by-zero override.
    always_comb begin
        if (sign_a_s ^ sign_b_s) begin
            prod_s = ~work_r + ONE_2NB;
        end else begin
            prod_s = work_r;
        end
        fix_hi_s = prod_s[2*NB-1:NB];
        fix_lo_s = prod_s[NB-1:0];
        fix_dz_s = 1'b0;
        if (is_div_s) begin
            if (b_zero_s) begin
                fix_hi_s = a_raw_r;
                fix_lo_s = {NB{1'b1}};
                fix_dz_s = 1'b1;
            end else begin
                fix_hi_s = neg_if(work_r[2*NB-1:NB], sign_a_s);
                fix_lo_s = neg_if(work_r[NB-1:0], sign_a_s ^ sign_b_s);
                fix_dz_s = 1'b0;
            end
        end else begin
            fix_hi_s = prod_s[2*NB-1:NB];
            fix_lo_s = prod_s[NB-1:0];
            fix_dz_s = 1'b0;
        end
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r  <= IDLE;
            op_r     <= {NB_OP{1'b0}};
            a_raw_r  <= ZERO_NB;
            b_raw_r  <= ZERO_NB;
            cnt_r    <= CNT_ZERO;
            work_r   <= ZERO_2NB;
            mcand_r  <= ZERO_2NB;
            mplier_r <= ZERO_NB;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dz_r     <= 1'b0;
            hi_r     <= ZERO_NB;
            lo_r     <= ZERO_NB;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (i_start) begin
                        op_r    <= i_op;
                        a_raw_r <= i_data_a;
                        b_raw_r <= i_data_b;
                        cnt_r   <= CNT_ZERO;
                        busy_r  <= 1'b1;
                        dz_r    <= 1'b0;
                        state_r <= CALC;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    // Count zero is the load step: magnitudes enter the working registers.
                    if (cnt_r == CNT_ZERO) begin
                        mplier_r <= abs_b_s;
                        cnt_r    <= CNT_ONE;
                        if (is_div_s) begin
                            work_r  <= {ZERO_NB, abs_a_s};
                            mcand_r <= {ZERO_NB, abs_b_s};
                        end else begin
                            work_r  <= ZERO_2NB;
                            mcand_r <= {ZERO_NB, abs_a_s};
                        end
                    end else begin
                        work_r   <= work_nxt_s;
                        mcand_r  <= mcand_nxt_s;
                        mplier_r <= mplier_nxt_s;
                        cnt_r    <= cnt_r + CNT_ONE;
                        if (last_iter_s) begin
                            state_r <= FIX;
                        end else begin
                            state_r <= CALC;
                        end
                    end
                end
                FIX: begin
                    hi_r    <= fix_hi_s;
                    lo_r    <= fix_lo_s;
                    dz_r    <= fix_dz_s;
                    done_r  <= 1'b1;
                    state_r <= DONE;
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign o_busy        = busy_r;
    assign o_done        = done_r;
    assign o_hi          = hi_r;
    assign o_lo          = lo_r;
    assign o_div_by_zero = dz_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table plus scoreboard, and hand-written
// sequences for ignored starts and reset in the middle of an operation.
module tb_mult_div_unit;
    logic        i_clk;
    logic        i_reset;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_data_a;
    logic [31:0] i_data_b;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_hi;
    logic [31:0] o_lo;
    logic        o_div_by_zero;

    mult_div_unit #(.NB(32), .NB_OP(2)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_op          (i_op),
        .i_data_a      (i_data_a),
        .i_data_b      (i_data_b),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_hi          (o_hi),
        .o_lo          (o_lo),
        .o_div_by_zero (o_div_by_zero)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        int          start_cyc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    vec_t        vq[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    logic [31:0] prev_hi = 32'h0;
    logic [31:0] prev_lo = 32'h0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_total++;
        if (act === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] hi, input logic [31:0] lo, input logic dz,
                                input string nm);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.dz = dz; v.name = nm;
        return v;
    endfunction

    // Reference model built on the language's own arithmetic operators.
    function automatic vec_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input string nm);
        logic signed [63:0] sa64, sb64, sp;
        logic        [63:0] up;
        logic signed [31:0] sa, sb, sq, sr;
        vec_t v;
        v = mk(op, a, b, 32'h0, 32'h0, 1'b0, nm);
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        sa = a;
        sb = b;
        case (op)
            2'd0: begin sp = sa64 * sb64; v.hi = sp[63:32]; v.lo = sp[31:0]; end
            2'd1: begin up = {32'h0, a} * {32'h0, b}; v.hi = up[63:32]; v.lo = up[31:0]; end
            default: begin
                if (b == 32'h0) begin
                    v.hi = a; v.lo = 32'hFFFF_FFFF; v.dz = 1'b1;
                end else if (op == 2'd3) begin
                    v.hi = a % b; v.lo = a / b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    v.hi = 32'h0; v.lo = 32'h8000_0000;
                end else begin
                    sq = sa / sb; sr = sa % sb; v.hi = sr; v.lo = sq;
                end
            end
        endcase
        return v;
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        logic [31:0] absb;
        int it;
        if (!op[1]) begin
            absb = (op == 2'd0 && b[31]) ? (~b + 32'h1) : b;
            it = 1;
            for (int i = 0; i < 32; i++) begin
                if (absb[i]) it = i + 1;
            end
            return it + 2;
        end
`endif
        return 34;
    endfunction

    // Scoreboard consumer: every o_done pulse must match the oldest pending expectation.
    always @(posedge i_clk) begin
        #1;
        if (o_done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(o_done), 64'h0);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_hi"}, 64'(o_hi), 64'(mon_e.hi));
                chk({mon_e.name, "_lo"}, 64'(o_lo), 64'(mon_e.lo));
                chk({mon_e.name, "_dz"}, 64'(o_div_by_zero), 64'(mon_e.dz));
                chk({mon_e.name, "_latency"}, 64'(cyc - mon_e.start_cyc), 64'(mon_e.lat));
                prev_hi = mon_e.hi;
                prev_lo = mon_e.lo;
            end
        end
    end

    task automatic start_op(input vec_t v, input bit push);
        exp_t e;
        @(negedge i_clk);
        i_op = v.op; i_data_a = v.a; i_data_b = v.b; i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        if (push) begin
            e.hi = v.hi; e.lo = v.lo; e.dz = v.dz; e.name = v.name;
            e.lat = exp_lat(v.op, v.b);
            e.start_cyc = cyc;
            sb.push_back(e);
        end
        chk({v.name, "_busy"}, 64'(o_busy), 64'h1);
        chk({v.name, "_dz_cleared"}, 64'(o_div_by_zero), 64'h0);
        chk({v.name, "_hi_hold"}, 64'(o_hi), 64'(prev_hi));
        chk({v.name, "_lo_hold"}, 64'(o_lo), 64'(prev_lo));
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge i_clk);
            n++;
        end
        #2;
        if (sb.size() != 0) begin
            chk({nm, "_timeout"}, 64'(sb.size()), 64'h0);
            sb.delete();
        end
    endtask

    initial begin
        int n_done;
        vec_t v;
        i_reset = 1'b1; i_start = 1'b1; i_op = 2'd1; i_data_a = 32'd5; i_data_b = 32'd6;
        repeat (2) @(posedge i_clk);
        #1;
        chk("reset_busy", 64'(o_busy), 64'h0);
        chk("reset_done", 64'(o_done), 64'h0);
        chk("reset_hi", 64'(o_hi), 64'h0);
        chk("reset_lo", 64'(o_lo), 64'h0);
        chk("reset_dz", 64'(o_div_by_zero), 64'h0);
        @(negedge i_clk);
        i_reset = 1'b0; i_start = 1'b0;
        @(posedge i_clk);
        #1;
        chk("idle_after_reset_busy", 64'(o_busy), 64'h0);

        vq.push_back(mk(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max"));
        vq.push_back(mk(2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult_neg"));
        vq.push_back(mk(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg"));
        vq.push_back(mk(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "div_ovf"));
        vq.push_back(mk(2'd3, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, "divu_zero"));
        vq.push_back(mk(2'd2, 32'hFFFF_FF9C, 32'h0000_0000, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 1'b1, "div_zero_neg"));
        vq.push_back(mk(2'd1, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 32'h1234_5678, 1'b0, "multu_by1"));
        vq.push_back(mk(2'd1, 32'h0000_0003, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0, "multu_msb"));
        vq.push_back(mk(2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, "div_negb"));
        vq.push_back(mk(2'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0, "divu_big"));
        vq.push_back(mk(2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, "mult_minmin"));
        vq.push_back(mk(2'd0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, "mult_by0"));
        for (int i = 0; i < 8; i++) begin
            vq.push_back(model(2'(i % 4), $urandom(), (i == 6) ? $urandom_range(1, 100) : $urandom(),
                               $sformatf("rand%0d", i)));
        end

        foreach (vq[i]) begin
            start_op(vq[i], 1'b1);
            wait_done(vq[i].name);
        end

        // A second request while busy must be dropped without touching the captured operands.
        v = mk(2'd1, 32'd5, 32'd6, 32'h0, 32'h1E, 1'b0, "ignore_start");
        start_op(v, 1'b1);
        repeat (4) @(negedge i_clk);
        i_op = 2'd0; i_data_a = 32'd9; i_data_b = 32'd9; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_done("ignore_start");

        // Reset ten cycles into an operation: no o_done, outputs cleared.
        v = mk(2'd3, 32'd1000, 32'd7, 32'h0, 32'h0, 1'b0, "rst_mid");
        start_op(v, 1'b0);
        repeat (9) @(negedge i_clk);
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        chk("rst_mid_busy", 64'(o_busy), 64'h0);
        chk("rst_mid_done", 64'(o_done), 64'h0);
        chk("rst_mid_hi", 64'(o_hi), 64'h0);
        chk("rst_mid_lo", 64'(o_lo), 64'h0);
        @(negedge i_clk);
        i_reset = 1'b0;
        prev_hi = 32'h0;
        prev_lo = 32'h0;
        n_done = 0;
        repeat (50) begin
            @(posedge i_clk);
            #1;
            if (o_done === 1'b1) n_done++;
        end
        chk("rst_mid_no_done", 64'(n_done), 64'h0);

        v = mk(2'd1, 32'd5, 32'd6, 32'h0, 32'h1E, 1'b0, "after_reset");
        start_op(v, 1'b1);
        wait_done("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
